// File: rtl/npc_state_sequencer.sv
// Switching-state sequencer for a 3-level NPC leg decoder: walks the three leg levels
// toward a requested code one level per step, honouring a minimum dwell, with a fault walk to 14.
//
// state | meaning
// IDLE  | holding current code, accepting requests
// WALK  | stepping toward the latched target
// FAULT | stepping toward / holding all-zero (code 14)
module npc_state_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] tgt_state,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic       fault,
    output logic [4:0] state,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fault_active
);

    typedef enum logic [1:0] {IDLE, WALK, FAULT} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [1:0]    la_q, lb_q, lc_q, la_d, lb_d, lc_d;
    logic [1:0]    ta_q, tb_q, tc_q, ta_d, tb_d, tc_d;
    logic [1:0]    ea, eb, ec;
    logic [CW-1:0] cnt_q;
    logic [4:0]    state_q, tv;
    logic          done_q, done_d, err_q, err_d;
    logic          dwell_ok, tgt_ok, stepping, moved, safe_tgt;

    function automatic logic [1:0] toward(input logic [1:0] cur, input logic [1:0] dst);
        return (cur < dst) ? cur + 2'd1 : cur - 2'd1;
    endfunction

    function automatic logic [4:0] encode(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
        return 5'd1 + {3'b000, a} + 5'd3 * {3'b000, b} + 5'd9 * {3'b000, c};
    endfunction

    // the counter value seen on a step edge is one less than the cycles already held
    assign dwell_ok = (cnt_q >= CW'(DWELL - 1));
    assign tgt_ok   = (tgt_state >= 5'd1) && (tgt_state <= 5'd27);
    assign tv       = tgt_state - 5'd1;
    assign safe_tgt = fault || (fsm_q == FAULT);
    assign stepping = (fsm_q != IDLE) || fault;
    assign ea       = safe_tgt ? 2'd1 : ta_q;
    assign eb       = safe_tgt ? 2'd1 : tb_q;
    assign ec       = safe_tgt ? 2'd1 : tc_q;

    always_comb begin
        fsm_d  = fsm_q;
        la_d   = la_q;
        lb_d   = lb_q;
        lc_d   = lc_q;
        ta_d   = ta_q;
        tb_d   = tb_q;
        tc_d   = tc_q;
        done_d = 1'b0;
        err_d  = 1'b0;

        if (stepping && dwell_ok) begin
            if (la_q != ea)      la_d = toward(la_q, ea);
            else if (lb_q != eb) lb_d = toward(lb_q, eb);
            else if (lc_q != ec) lc_d = toward(lc_q, ec);
        end

        case (fsm_q)
            IDLE: begin
                if (fault) begin
                    fsm_d = FAULT;
                    {ta_d, tb_d, tc_d} = {2'd1, 2'd1, 2'd1};
                end else if (tgt_valid) begin
                    if (tgt_ok) begin
                        ta_d  = 2'(tv % 5'd3);
                        tb_d  = 2'((tv / 5'd3) % 5'd3);
                        tc_d  = 2'(tv / 5'd9);
                        fsm_d = WALK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WALK: begin
                if (fault) begin
                    fsm_d = FAULT;
                    {ta_d, tb_d, tc_d} = {2'd1, 2'd1, 2'd1};
                end else if (la_d == ea && lb_d == eb && lc_d == ec) begin
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end
            end
            FAULT: begin
                if (!fault && la_q == 2'd1 && lb_q == 2'd1 && lc_q == 2'd1) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign moved = {la_d, lb_d, lc_d} != {la_q, lb_q, lc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            la_q    <= 2'd1;
            lb_q    <= 2'd1;
            lc_q    <= 2'd1;
            ta_q    <= 2'd1;
            tb_q    <= 2'd1;
            tc_q    <= 2'd1;
            state_q <= 5'd14;
            cnt_q   <= CW'(DWELL);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            lc_q    <= lc_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            tc_q    <= tc_d;
            state_q <= encode(la_d, lb_d, lc_d);
            done_q  <= done_d;
            err_q   <= err_d;
            if (moved)                    cnt_q <= '0;
            else if (cnt_q != CW'(DWELL)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign state        = state_q;
    assign busy         = (fsm_q == WALK);
    assign fault_active = (fsm_q == FAULT);
    assign tgt_ready    = (fsm_q == IDLE) && !fault;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_npc_state_sequencer.sv
// Bench for npc_state_sequencer: code-level reference model checked every cycle,
// directed scenarios with hand-computed step sequences, and a single-leg-step invariant monitor.
module tb_npc_state_sequencer;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] tgt_state = 5'd0;
    logic       tgt_valid = 1'b0;
    logic       fault = 1'b0;
    logic       tgt_ready, busy, done, err, fault_active;
    logic [4:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    npc_state_sequencer #(.DWELL(DWELL), .CW(8)) dut (
        .clk(clk), .rst(rst), .tgt_state(tgt_state), .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready), .fault(fault), .state(state), .busy(busy),
        .done(done), .err(err), .fault_active(fault_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in terms of the state code and per-leg digits.
    int m_cur = 14, m_held = DWELL, m_tgt = 14, m_mode = 0; // mode: 0 idle, 1 walk, 2 fault
    bit m_done = 0, m_err = 0;

    function automatic int digit(input int code, input int k);
        int w;
        w = (k == 0) ? 1 : (k == 1) ? 3 : 9;
        return ((code - 1) / w) % 3;
    endfunction

    function automatic int step_toward(input int cur, input int dst);
        int w;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 1 : (k == 1) ? 3 : 9;
            if (digit(cur, k) < digit(dst, k)) return cur + w;
            if (digit(cur, k) > digit(dst, k)) return cur - w;
        end
        return cur;
    endfunction

    always @(posedge clk or posedge rst) begin
        int eff, nxt;
        if (rst) begin
            m_cur = 14; m_held = DWELL; m_tgt = 14; m_mode = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            eff = (fault || m_mode == 2) ? 14 : m_tgt;
            nxt = ((m_mode != 0 || fault) && m_held >= DWELL) ? step_toward(m_cur, eff) : m_cur;
            if (m_mode == 0) begin
                if (fault) begin m_mode = 2; m_tgt = 14; end
                else if (tgt_valid) begin
                    if (tgt_state >= 1 && tgt_state <= 27) begin m_tgt = tgt_state; m_mode = 1; end
                    else m_err = 1;
                end
            end else if (m_mode == 1) begin
                if (fault) begin m_mode = 2; m_tgt = 14; end
                else if (nxt == eff) begin m_done = 1; m_mode = 0; end
            end else begin
                if (!fault && m_cur == 14) m_mode = 0;
            end
            if (nxt != m_cur) begin m_cur = nxt; m_held = 1; end
            else if (m_held < DWELL) m_held++;
        end
    end

    int prev_state = 14;
    always @(negedge clk) begin
        int legs, big;
        if (rst) prev_state = 14;
        else begin
            chk("m_state", state, m_cur);
            chk("m_busy", busy, (m_mode == 1) ? 1 : 0);
            chk("m_done", done, m_done);
            chk("m_err", err, m_err);
            chk("m_fault_active", fault_active, (m_mode == 2) ? 1 : 0);
            chk("m_ready", tgt_ready, (m_mode == 0 && !fault) ? 1 : 0);
            if (state != prev_state) begin
                legs = 0; big = 0;
                for (int k = 0; k < 3; k++) begin
                    if (digit(state, k) != digit(prev_state, k)) legs++;
                    if (digit(state, k) - digit(prev_state, k) > 1 ||
                        digit(prev_state, k) - digit(state, k) > 1) big++;
                end
                chk("inv_legs", legs, 1);
                chk("inv_np_jump", big, 0);
            end
            prev_state = state;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int code, input int maxc);
        int k;
        k = 0;
        while (state != code && k < maxc) begin cyc(); k++; end
        chk("reach_state", state, code);
    endtask

    int chg_idx[$];
    int chg_val[$];
    int done_seen, done_at;

    task automatic collect(input int n);
        int prev;
        prev = state;
        chg_idx.delete(); chg_val.delete();
        done_seen = 0; done_at = -1;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (state != prev) begin chg_idx.push_back(i); chg_val.push_back(state); end
            prev = state;
            if (done) begin done_seen++; done_at = i; end
        end
    endtask

    task automatic request(input int code);
        tgt_state = 5'(code);
        tgt_valid = 1'b1;
        cyc();
        tgt_valid = 1'b0;
    endtask

    initial begin
        int exp_idx[6];
        int exp_val[6];
        int fexp_idx[3];
        int fexp_val[3];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_state", state, 14);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);

        // 14 -> 27: 15 @1, 18 @5, 27 @9, done only @9
        request(27);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("w27_state", state, (k < 5) ? 15 : (k < 9) ? 18 : 27);
            chk("w27_done", done, (k == 9) ? 1 : 0);
            chk("w27_busy", busy, (k < 9) ? 1 : 0);
        end

        // 27 -> 1, accepted one cycle after arriving at 27
        request(1);
        collect(26);
        exp_idx = '{3, 7, 11, 15, 19, 23};
        exp_val = '{26, 25, 22, 19, 10, 1};
        chk("w1_nchg", chg_idx.size(), 6);
        for (int i = 0; i < 6 && i < chg_idx.size(); i++) begin
            chk("w1_idx", chg_idx[i], exp_idx[i]);
            chk("w1_val", chg_val[i], exp_val[i]);
        end
        chk("w1_done_cnt", done_seen, 1);
        chk("w1_done_at", done_at, 23);

        // invalid targets
        request(0);
        chk("t0_err", err, 1);
        chk("t0_state", state, 1);
        chk("t0_ready", tgt_ready, 1);
        cyc();
        chk("t0_err_clr", err, 0);
        request(28);
        chk("t28_err", err, 1);
        chk("t28_state", state, 1);
        cyc();
        chk("t28_err_clr", err, 0);

        // target equal to current
        request(1);
        chk("eq_done_early", done, 0);
        cyc();
        chk("eq_done", done, 1);
        chk("eq_state", state, 1);
        chk("eq_busy", busy, 0);

        // 1 -> 27 interrupted by fault at state 3: 3 -> 2 -> 5 -> 14
        request(27);
        wait_state(3, 20);
        fault = 1'b1;
        collect(14);
        fexp_idx = '{4, 8, 12};
        fexp_val = '{2, 5, 14};
        chk("f_nchg", chg_idx.size(), 3);
        for (int i = 0; i < 3 && i < chg_idx.size(); i++) begin
            chk("f_idx", chg_idx[i], fexp_idx[i]);
            chk("f_val", chg_val[i], fexp_val[i]);
        end
        chk("f_done_cnt", done_seen, 0);
        chk("f_active", fault_active, 1);
        fault = 1'b0;
        cyc();
        chk("f_exit_active", fault_active, 0);
        chk("f_exit_done", done, 0);
        chk("f_exit_ready", tgt_ready, 1);
        chk("f_exit_state", state, 14);

        // fault and request together while idle at 14
        fault = 1'b1;
        tgt_state = 5'd27;
        tgt_valid = 1'b1;
        #1 chk("fv_ready", tgt_ready, 0);
        cyc();
        tgt_valid = 1'b0;
        chk("fv_state", state, 14);
        chk("fv_active", fault_active, 1);
        cyc();
        fault = 1'b0;
        #1 chk("fv_ready_hold", tgt_ready, 0);
        cyc();
        chk("fv_ready_back", tgt_ready, 1);
        chk("fv_busy", busy, 0);

        // reset mid-walk at 18
        request(27);
        wait_state(18, 20);
        rst = 1'b1;
        #1;
        chk("rmid_state", state, 14);
        chk("rmid_busy", busy, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rmid_ready", tgt_ready, 1);
        chk("rmid_state2", state, 14);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
